xbar_alloc: RTL

Switch allocator for the 3-port ring router crossbar. It owns each crossbar output port and runs a per-output round-robin among the input ports whose head flit targets it. Once a packet's head flit wins an output, that output stays locked to the input until the tail flit has passed. The block drives the crossbar's one-hot `sel0..sel2` selects and returns per-input grants to the input buffers.

---
 rtl/noc_pkg.sv | 24 ++
 rtl/xbar_alloc_rr_arb3.sv | 56 +++++
 rtl/xbar_alloc.sv | 139 +++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared ring-router definitions: port index type, crossbar one-hot select codes,
// and the helper that maps a port index onto its select code.
package noc_pkg;

    typedef logic [1:0] port_idx_t;

    localparam logic [2:0] SEL_NONE    = 3'b000;
    localparam logic [2:0] SEL_P0      = 3'b001;
    localparam logic [2:0] SEL_P1      = 3'b010;
    localparam logic [2:0] SEL_P2      = 3'b100;
    localparam port_idx_t  DST_ILLEGAL = 2'd3;

    function automatic logic [2:0] onehot3(input port_idx_t p);
        logic [2:0] code;
        case (p)
            2'd0:    code = SEL_P0;
            2'd1:    code = SEL_P1;
            2'd2:    code = SEL_P2;
            default: code = SEL_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/xbar_alloc_rr_arb3.sv
// Combinational 3-requester round-robin picker: search starts just after ptr
// and wraps, so the last winner has lowest priority.
module rr_arb3
    import noc_pkg::*;
(
    input  logic [2:0] req,
    input  port_idx_t  ptr,
    output logic [2:0] gnt,
    output port_idx_t  win
);

    port_idx_t first_s;
    port_idx_t second_s;
    port_idx_t third_s;

    // Rotate the search order so it begins at ptr+1 (mod 3).
    always_comb begin
        case (ptr)
            2'd0: begin
                first_s  = 2'd1;
                second_s = 2'd2;
                third_s  = 2'd0;
            end
            2'd1: begin
                first_s  = 2'd2;
                second_s = 2'd0;
                third_s  = 2'd1;
            end
            default: begin
                first_s  = 2'd0;
                second_s = 2'd1;
                third_s  = 2'd2;
            end
        endcase
    end

    // Pick the first requester in rotated order.
    always_comb begin
        gnt = SEL_NONE;
        win = 2'd0;
        if (req[first_s]) begin
            gnt = onehot3(first_s);
            win = first_s;
        end else if (req[second_s]) begin
            gnt = onehot3(second_s);
            win = second_s;
        end else if (req[third_s]) begin
            gnt = onehot3(third_s);
            win = third_s;
        end else begin
            gnt = SEL_NONE;
            win = 2'd0;
        end
    end

endmodule

// File: rtl/xbar_alloc.sv
// Switch allocator for the 3-port crossbar: per-output round-robin with
// wormhole locking from head flit until the tail flit has transferred.
module xbar_alloc
    import noc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       vld0,
    input  logic       vld1,
    input  logic       vld2,
    input  logic [1:0] dst0,
    input  logic [1:0] dst1,
    input  logic [1:0] dst2,
    input  logic       tail0,
    input  logic       tail1,
    input  logic       tail2,
    input  logic       rdy0,
    input  logic       rdy1,
    input  logic       rdy2,
    output logic [2:0] sel0,
    output logic [2:0] sel1,
    output logic [2:0] sel2,
    output logic       gnt0,
    output logic       gnt1,
    output logic       gnt2,
    output logic [2:0] lock
);

    logic [2:0] vld_s;
    logic [2:0] tail_s;
    logic [2:0] rdy_s;
    port_idx_t  dst_s [3];

    logic [2:0] lock_r;
    port_idx_t  own_r [3];
    port_idx_t  ptr_r [3];

    logic [2:0] bound_s;
    logic [2:0] cand_s    [3];
    logic [2:0] arb_gnt_s [3];
    port_idx_t  arb_win_s [3];
    logic [2:0] sel_s     [3];
    logic [2:0] xfer_s;
    logic [2:0] gnt_s;

    assign vld_s  = {vld2, vld1, vld0};
    assign tail_s = {tail2, tail1, tail0};
    assign rdy_s  = {rdy2, rdy1, rdy0};
    assign dst_s[0] = dst0;
    assign dst_s[1] = dst1;
    assign dst_s[2] = dst2;

    // An input owning a locked output may not compete anywhere else.
    always_comb begin
        bound_s = 3'b000;
        for (int o = 0; o < 3; o++) begin
            if (lock_r[o]) begin
                bound_s[own_r[o]] = 1'b1;
            end else begin
                bound_s = bound_s;
            end
        end
    end

    // Candidate matrix: cand_s[o][i] = unbound input i requests output o.
    always_comb begin
        for (int o = 0; o < 3; o++) begin
            cand_s[o] = 3'b000;
            for (int i = 0; i < 3; i++) begin
                cand_s[o][i] = vld_s[i] && !bound_s[i] &&
                               (dst_s[i] != DST_ILLEGAL) && (dst_s[i] == 2'(o));
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_arb
        rr_arb3 u_arb (
            .req (cand_s[g]),
            .ptr (ptr_r[g]),
            .gnt (arb_gnt_s[g]),
            .win (arb_win_s[g])
        );
    end

    // Per-output select: locked outputs serve only their owner, idle ones the arbiter.
    always_comb begin
        gnt_s  = 3'b000;
        xfer_s = 3'b000;
        for (int o = 0; o < 3; o++) begin
            if (!rdy_s[o]) begin
                sel_s[o] = SEL_NONE;
            end else if (lock_r[o]) begin
                if (vld_s[own_r[o]]) begin
                    sel_s[o] = onehot3(own_r[o]);
                end else begin
                    sel_s[o] = SEL_NONE;
                end
            end else begin
                sel_s[o] = arb_gnt_s[o];
            end
            xfer_s[o] = |sel_s[o];
            gnt_s     = gnt_s | sel_s[o];
        end
    end

    // Lock/owner/pointer state; a tail leaving frees the output only from next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_r <= 3'b000;
            for (int o = 0; o < 3; o++) begin
                own_r[o] <= 2'd0;
                ptr_r[o] <= 2'd2;
            end
        end else begin
            for (int o = 0; o < 3; o++) begin
                if (!lock_r[o]) begin
                    if (xfer_s[o]) begin
                        ptr_r[o] <= arb_win_s[o];
                        if (!tail_s[arb_win_s[o]]) begin
                            lock_r[o] <= 1'b1;
                            own_r[o]  <= arb_win_s[o];
                        end
                    end
                end else if (xfer_s[o] && tail_s[own_r[o]]) begin
                    lock_r[o] <= 1'b0;
                end
            end
        end
    end

    assign sel0 = sel_s[0];
    assign sel1 = sel_s[1];
    assign sel2 = sel_s[2];
    assign gnt0 = gnt_s[0];
    assign gnt1 = gnt_s[1];
    assign gnt2 = gnt_s[2];
    assign lock = lock_r;

endmodule
